// File: rtl/muldiv_unit.sv
// muldiv_unit
// Sequential signed multiply / divide unit that sits beside the combinational
// ALU and feeds the Z register pair. An operation is launched with a
// one-cycle start, runs for a fixed 33 cycles, then issues a one-cycle done
// pulse. The results stay valid after the pulse.
//   Multiply: radix-2 Booth on a 33-bit A accumulator plus Q and q-1.
//   Divide:   restoring division on magnitudes, followed by sign correction.
//             The quotient truncates toward zero and the remainder takes the
//             dividend's sign.
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   start      in   launch request, sampled only in IDLE
//   op         in   0 = signed multiply, 1 = signed divide
//   operand_a  in   multiplicand / dividend
//   operand_b  in   multiplier / divisor
//   result_hi  out  product[2W-1:W] / remainder
//   result_lo  out  product[W-1:0]  / quotient
//   busy       out  high from the accept edge until done is issued
//   done       out  one-cycle completion pulse
//   div_zero   out  divide had a zero divisor (valid with done)
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Output registers
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic [WIDTH-1:0] result_lo_q, result_lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   // Datapath registers. acc_hi holds the Booth A (multiply) or the partial
   // remainder R (divide); acc_lo holds Q in both modes.
   logic signed [WIDTH:0]   acc_hi_q, acc_hi_d;
   logic        [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic                    qm1_q, qm1_d;
   logic        [WIDTH-1:0] mcand_q, mcand_d;
   logic        [WIDTH-1:0] a_q, a_d;
   logic                    op_q, op_d;
   logic                    neg_quo_q, neg_quo_d;
   logic                    neg_rem_q, neg_rem_d;
   logic                    dz_q, dz_d;

   // Magnitude of a two's-complement value. The most negative value maps to
   // 2^(W-1), which still fits as an unsigned W-bit number.
   function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
      abs_mag = v[WIDTH-1] ? WIDTH'(-v) : v;
   endfunction

   // Conditional two's-complement negation; wraps for the overflow case.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic            neg);
      cond_neg = neg ? WIDTH'(-v) : v;
   endfunction

   // ---- State register ----
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         result_hi_q <= '0;
         result_lo_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         result_hi_q <= result_hi_d;
         result_lo_q <= result_lo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
      end
   end

   // Datapath registers carry no reset; they are always loaded on accept.
   always_ff @(posedge clock) begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      a_q       <= a_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
   end

   // ---- Next-state logic ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = CNT_LOAD;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---- Datapath step ----
   always_comb begin
      logic signed [WIDTH:0] m_ext;
      logic signed [WIDTH:0] sum;
      logic        [WIDTH:0] r_sh;
      logic        [WIDTH:0] trial;

      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      qm1_d     = qm1_q;
      mcand_d   = mcand_q;
      a_d       = a_q;
      op_d      = op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;

      m_ext = {mcand_q[WIDTH-1], mcand_q};
      sum   = acc_hi_q;
      r_sh  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
      trial = r_sh - {1'b0, mcand_q};

      if (state_q == S_IDLE && start) begin
         op_d      = op;
         a_d       = operand_a;
         acc_hi_d  = '0;
         qm1_d     = 1'b0;
         neg_quo_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
         neg_rem_d = operand_a[WIDTH-1];
         dz_d      = op && (operand_b == '0);
         if (op) begin
            acc_lo_d = abs_mag(operand_a);
            mcand_d  = abs_mag(operand_b);
         end else begin
            acc_lo_d = operand_b;
            mcand_d  = operand_a;
         end
      end else if (state_q == S_RUN) begin
         if (!op_q) begin
            // Booth: 01 adds, 10 subtracts the multiplicand, then an
            // arithmetic shift right of {A, Q, q-1}.
            unique case ({acc_lo_q[0], qm1_q})
               2'b01:   sum = acc_hi_q + m_ext;
               2'b10:   sum = acc_hi_q - m_ext;
               default: sum = acc_hi_q;
            endcase
            acc_hi_d = {sum[WIDTH], sum[WIDTH:1]};
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            qm1_d    = acc_lo_q[0];
         end else begin
            // Restoring step: shift {R,Q} left and keep the trial difference
            // only if it did not go negative.
            if (!trial[WIDTH]) begin
               acc_hi_d = trial;
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi_d = r_sh;
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // ---- Output logic ----
   always_comb begin
      result_hi_d = result_hi_q;
      result_lo_d = result_lo_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d     = 1'b1;
               div_zero_d = 1'b0;
            end
         end
         S_FIX: begin
            busy_d     = 1'b0;
            done_d     = 1'b1;
            div_zero_d = dz_q;
            if (!op_q) begin
               result_hi_d = acc_hi_q[WIDTH-1:0];
               result_lo_d = acc_lo_q;
            end else if (dz_q) begin
               result_hi_d = a_q;
               result_lo_d = '1;
            end else begin
               result_hi_d = cond_neg(acc_hi_q[WIDTH-1:0], neg_rem_q);
               result_lo_d = cond_neg(acc_lo_q, neg_quo_q);
            end
         end
         default: ;
      endcase
   end

   assign result_hi = result_hi_q;
   assign result_lo = result_lo_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors for multiply and
// divide, including the corner cases, busy-time input changes and a clear
// asserted in the middle of an operation.
module tb_muldiv_unit;

   logic        clock;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .result_hi (result_hi),
      .result_lo (result_lo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one operation and check busy, latency, results and done width.
   task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz);
      int n;
      @(negedge clock);
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clock);
      #1;
      chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
      @(negedge clock);
      start = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            n = i;
            break;
         end
      end
      chk({tag, "_latency"}, 64'(n), 64'd33);
      chk({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
      chk({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      chk({tag, "_done_fall"}, 64'(done), 64'd0);
      chk({tag, "_lo_held"}, 64'(result_lo), 64'(exp_lo));
   endtask

   initial begin
      int done_cnt;
      int done_at;
      logic [31:0] hi_cap;
      logic [31:0] lo_cap;

      clear = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
      #12;
      chk("reset_hi", 64'(result_hi), 64'd0);
      chk("reset_lo", 64'(result_lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      @(negedge clock);
      clear = 1'b0;

      run_op("mul_6x-7", 1'b0, 32'h0000_0006, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
      run_op("mul_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("mul_-1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
      run_op("div_-17/5", 1'b1, 32'hFFFF_FFEF, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      run_op("div_7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("div_100/0", 1'b1, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
      run_op("div_100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

      // 20 / 3 with a second start and operand changes while busy.
      @(negedge clock);
      op = 1'b1; operand_a = 32'd20; operand_b = 32'd3; start = 1'b1;
      @(posedge clock);
      done_cnt = 0; done_at = 0; hi_cap = '0; lo_cap = '0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clock);
         start = (n == 5);
         if (n == 6) begin
            operand_a = '0; operand_b = '0; op = 1'b0;
         end
         @(posedge clock);
         #1;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_at = n; hi_cap = result_hi; lo_cap = result_lo;
            end
         end
      end
      chk("busy_ign_done_count", 64'(done_cnt), 64'd1);
      chk("busy_ign_latency", 64'(done_at), 64'd33);
      chk("busy_ign_lo", 64'(lo_cap), 64'd6);
      chk("busy_ign_hi", 64'(hi_cap), 64'd2);

      // Clear during RUN iteration 10; outputs must drop before the next edge.
      @(negedge clock);
      op = 1'b1; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(posedge clock);
      #3;
      clear = 1'b1;
      #1;
      chk("midclr_hi", 64'(result_hi), 64'd0);
      chk("midclr_lo", 64'(result_lo), 64'd0);
      chk("midclr_busy", 64'(busy), 64'd0);
      chk("midclr_done", 64'(done), 64'd0);
      chk("midclr_div_zero", 64'(div_zero), 64'd0);
      @(negedge clock);
      clear = 1'b0;

      run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
